noc_input_port_requester: RTL

Per-input-port, per-VC request generator and flit sequencer: the initiator side of the port-control handshake that the output-port controllers answer. It watches the head flit of each VC buffer on one router input port, raises a request and start-of-packet toward the routed output port's controller, waits for that controller's grant, then streams the packet out of the VC buffer. It signals free to the same controller on the tail flit. One instance sits between the input VC buffers and the crossbar for each of the five router ports.

---
 rtl/noc_input_port_requester.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/noc_input_port_requester.sv
// noc_input_port_requester
//   Initiator side of the input-port / output-controller handshake for one
//   router input port. Each VC has its own sequencer. When the head flit of a
//   VC buffer is a packet head, the sequencer requests the routed output
//   controller and waits for its grant. It then streams the packet to the
//   crossbar and releases the controller on the tail flit.
// Ports
//   noc_clk, noc_rst_n   clock, synchronous active-low reset
//   head_*_i             head-flit status of each VC buffer
//   head_pop_o           pop the head flit of each VC buffer
//   request_o, start_of_packet_o, free_o, grant_i
//                        handshake with the output controllers, [port][vc]
//   flit_ready_i, flit_valid_o, flit_sel_o
//                        crossbar side, flit_sel_o is a one-hot output port select
//   error_o              sticky protocol error per VC

// Sequencer for a single VC
module noc_ipr_vc #(
  parameter int PORTS = 5
) (
  input  logic             noc_clk,
  input  logic             noc_rst_n,
  input  logic             head_valid_i,
  input  logic             head_sop_i,
  input  logic             head_eop_i,
  input  logic [2:0]       head_route_i,
  input  logic [PORTS-1:0] grant_i,
  input  logic             flit_ready_i,
  output logic             head_pop_o,
  output logic             flit_valid_o,
  output logic [PORTS-1:0] request_o,
  output logic [PORTS-1:0] start_of_packet_o,
  output logic [PORTS-1:0] free_o,
  output logic [PORTS-1:0] sel_o,
  output logic             error_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;
  localparam logic [3:0] PORTS_L = 4'(PORTS);

  logic [1:0] state_q, state_d;
  logic [2:0] route_q, route_d;
  logic       err_q, err_d;
  logic       route_ok;

  assign route_ok = ({1'b0, head_route_i} < PORTS_L);
  assign error_o  = err_q;

  // The combinational strobes are held low while reset is asserted.
  // This keeps a buffer from being popped while the controllers are
  // being reset.
  always_comb begin
    head_pop_o   = 1'b0;
    flit_valid_o = 1'b0;
    if (noc_rst_n && head_valid_i) begin
      unique case (state_q)
        S_IDLE: head_pop_o = !head_sop_i;   // discard an orphan body flit
        S_XFER: begin
          head_pop_o   = flit_ready_i;
          flit_valid_o = 1'b1;
        end
        S_DROP: head_pop_o = 1'b1;          // drain without waiting on the crossbar
        default: head_pop_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      request_o[p]         = (state_q == S_REQ)  && (route_q == 3'(p));
      start_of_packet_o[p] = (state_q == S_REQ)  && (route_q == 3'(p));
      sel_o[p]             = (state_q == S_XFER) && (route_q == 3'(p));
      free_o[p]            = (state_q == S_XFER) && (route_q == 3'(p))
                             && head_pop_o && head_eop_i;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (head_valid_i) begin
        if (!head_sop_i) err_d = 1'b1;
        else if (route_ok) begin
          state_d = S_REQ;
          route_d = head_route_i;
        end else begin
          state_d = S_DROP;
          err_d   = 1'b1;
        end
      end
      // request_o is one-hot on the latched route.
      // The AND therefore ignores grants that arrive on other ports.
      S_REQ:  if (|(grant_i & request_o)) state_d = S_XFER;
      S_XFER: if (head_pop_o && head_eop_i) state_d = S_IDLE;
      S_DROP: if (head_pop_o && head_eop_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state_q <= S_IDLE;
      route_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= err_d;
    end
  end
endmodule

module noc_input_port_requester #(
  parameter int CHANNELS = 2,   // router VC count
  parameter int PORTS    = 5
) (
  input  logic                               noc_clk,
  input  logic                               noc_rst_n,
  input  logic [CHANNELS-1:0]                head_valid_i,
  input  logic [CHANNELS-1:0]                head_sop_i,
  input  logic [CHANNELS-1:0]                head_eop_i,
  input  logic [CHANNELS-1:0][2:0]           head_route_i,
  output logic [CHANNELS-1:0]                head_pop_o,
  output logic [PORTS-1:0][CHANNELS-1:0]     request_o,
  output logic [PORTS-1:0][CHANNELS-1:0]     start_of_packet_o,
  output logic [PORTS-1:0][CHANNELS-1:0]     free_o,
  input  logic [PORTS-1:0][CHANNELS-1:0]     grant_i,
  input  logic [CHANNELS-1:0]                flit_ready_i,
  output logic [CHANNELS-1:0]                flit_valid_o,
  output logic [CHANNELS-1:0][PORTS-1:0]     flit_sel_o,
  output logic [CHANNELS-1:0]                error_o
);
  // The controller handshake is indexed [port][vc].
  // The sequencers work on per-VC columns, so these wires transpose the arrays.
  logic [CHANNELS-1:0][PORTS-1:0] gnt_col, req_col, sop_col, free_col;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_vc
    for (genvar p = 0; p < PORTS; p++) begin : g_port
      assign gnt_col[c][p]           = grant_i[p][c];
      assign request_o[p][c]         = req_col[c][p];
      assign start_of_packet_o[p][c] = sop_col[c][p];
      assign free_o[p][c]            = free_col[c][p];
    end

    noc_ipr_vc #(.PORTS(PORTS)) u_vc (
      .noc_clk           (noc_clk),
      .noc_rst_n         (noc_rst_n),
      .head_valid_i      (head_valid_i[c]),
      .head_sop_i        (head_sop_i[c]),
      .head_eop_i        (head_eop_i[c]),
      .head_route_i      (head_route_i[c]),
      .grant_i           (gnt_col[c]),
      .flit_ready_i      (flit_ready_i[c]),
      .head_pop_o        (head_pop_o[c]),
      .flit_valid_o      (flit_valid_o[c]),
      .request_o         (req_col[c]),
      .start_of_packet_o (sop_col[c]),
      .free_o            (free_col[c]),
      .sel_o             (flit_sel_o[c]),
      .error_o           (error_o[c])
    );
  end
endmodule
